// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline hazard controller. Resolves data-memory waits,
//            control redirects and load-use hazards into per-stage load
//            enables and NOP-flush controls, counts stalled cycles and
//            flags over-long memory waits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int CntWidth      = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_rd,
    input  logic                ex_redirect,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                id_ex_en,
    output logic                ex_mem_en,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                mem_wb_bubble,
    output logic [CntWidth-1:0] stall_cnt,
    output logic                mem_timeout
);

    // Wait counter is just wide enough to hold TimeoutCycles; it saturates there.
    localparam int WaitW = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [WaitW:0]      WaitLimit = (WaitW + 1)'(TimeoutCycles);
    localparam logic [WaitW:0]      WaitOne   = (WaitW + 1)'(1);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             load_use;
    logic             freeze;
    logic [WaitW-1:0] wait_cnt;
    logic [WaitW:0]   wait_inc;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // In MEM_WAIT only the ready handshake releases the pipeline.
    assign freeze   = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    assign wait_inc = {1'b0, wait_cnt} + WaitOne;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stage controls, by priority: freeze, redirect, load-use.
    always_comb begin
        next_state    = state;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            // Hold the whole pipe in NOPs while reset is asserted.
            next_state    = RUN;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            next_state    = MEM_WAIT;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else begin
            next_state = RUN;
            if (ex_redirect) begin
                // Redirect squashes the younger instructions, hazard or not.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if ((state == RUN) && freeze) begin
            wait_cnt <= '0;
        end else if ((state == MEM_WAIT) && !mem_ready) begin
            if (wait_inc <= WaitLimit) begin
                wait_cnt <= wait_inc[WaitW-1:0];
            end
            if (wait_inc >= WaitLimit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != {CntWidth{1'b1}})) begin
            stall_cnt <= stall_cnt + CntOne;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//            plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_req, mem_ready;

    logic        pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a;
    logic        if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a, timeout_a;
    logic [31:0] stall_a;
    logic        pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b;
    logic        if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b, timeout_b;
    logic [3:0]  stall_b;
    logic [6:0]  outs_a, outs_b;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    bit     m_wait;
    int     m_wc;
    longint m_stall_a;
    int     m_stall_b;
    bit     m_to_a, m_to_b;

    assign outs_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a,
                     if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a};
    assign outs_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b,
                     if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a),
        .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
        .mem_wb_bubble(mem_wb_bubble_a), .stall_cnt(stall_a), .mem_timeout(timeout_a)
    );

    pipe_hazard_ctrl #(.CntWidth(4), .TimeoutCycles(4)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b),
        .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
        .mem_wb_bubble(mem_wb_bubble_b), .stall_cnt(stall_b), .mem_timeout(timeout_b)
    );

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic ld, input logic [4:0] rd,
                          input logic redir, input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_is_load = ld; ex_rd = rd; ex_redirect = redir; mem_req = req; mem_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Expected stage controls {pc,if_id,id_ex,ex_mem,if_flush,id_flush,bubble}.
    function automatic logic [6:0] model_outs();
        bit hz, frz;
        hz  = ex_is_load && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        frz = m_wait ? !mem_ready : (mem_req && !mem_ready);
        if (frz)              return 7'b0000_001;
        else if (ex_redirect) return 7'b1111_110;
        else if (hz)          return 7'b0011_010;
        else                  return 7'b1111_000;
    endfunction

    task automatic model_update();
        logic [6:0] o;
        o = model_outs();
        if (!o[6]) begin
            if (m_stall_a < 64'd4294967295) m_stall_a++;
            if (m_stall_b < 15) m_stall_b++;
        end
        if (o == 7'b0000_001) begin
            if (m_wait) begin
                m_wc++;
                if (m_wc >= 255) m_to_a = 1'b1;
                if (m_wc >= 4)   m_to_b = 1'b1;
            end else begin
                m_wait = 1'b1;
                m_wc   = 0;
            end
        end else begin
            m_wait = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #12;
        checks++;
        if (outs_a !== 7'b0000_111 || outs_b !== 7'b0000_111) begin
            failures++;
            $display("FAIL reset_outs a=%b b=%b want=0000111", outs_a, outs_b);
        end
        checks++;
        if (stall_a !== 32'd0 || stall_b !== 4'd0 || timeout_a !== 1'b0 || timeout_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs stall_a=%0d stall_b=%0d to_a=%b to_b=%b want 0", stall_a, stall_b, timeout_a, timeout_b);
        end
        @(negedge clk);
        rst = 1'b1;
        set_in(4, 0, 1, 0, 1, 4, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b0011_010) begin
            failures++;
            $display("FAIL reset_first_run got=%b want=0011010", outs_a);
        end
        @(negedge clk);
        checks++;
        if (stall_a !== 32'd1) begin
            failures++;
            $display("FAIL reset_first_stall got=%0d want=1", stall_a);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b0011_010) begin
            failures++;
            $display("FAIL load_use_rs1 got=%b want=0011010", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000 || stall_a !== 32'd1) begin
            failures++;
            $display("FAIL load_use_one_bubble outs=%b stall=%0d want=1111000 stall=1", outs_a, stall_a);
        end
        @(negedge clk);
        set_in(1, 9, 1, 1, 1, 9, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b0011_010) begin
            failures++;
            $display("FAIL load_use_rs2 got=%b want=0011010", outs_a);
        end
        @(negedge clk);
        set_in(9, 2, 0, 1, 1, 9, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL load_use_unused_rs got=%b want=1111000", outs_a);
        end
        @(negedge clk);
        set_in(9, 0, 1, 0, 0, 9, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL load_use_not_load got=%b want=1111000", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_a !== 32'd2) begin
            failures++;
            $display("FAIL load_use_count got=%0d want=2", stall_a);
        end
    endtask

    task automatic test_x0_redirect();
        do_reset();
        @(negedge clk);
        set_in(0, 0, 1, 1, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL x0_no_stall got=%b want=1111000", outs_a);
        end
        @(negedge clk);
        set_in(7, 0, 1, 0, 1, 7, 1, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_110) begin
            failures++;
            $display("FAIL redirect_over_hazard got=%b want=1111110", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_a !== 32'd0) begin
            failures++;
            $display("FAIL redirect_no_count got=%0d want=0", stall_a);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            checks++;
            if (outs_a !== 7'b0000_001) begin
                failures++;
                $display("FAIL mem_freeze_%0d got=%b want=0000001", i, outs_a);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL mem_ready_advance got=%b want=1111000", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (stall_a !== 32'd3 || outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL mem_wait_count stall=%0d outs=%b want stall=3 outs=1111000", stall_a, outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (outs_a !== 7'b0000_001) begin
            failures++;
            $display("FAIL mem_over_redirect got=%b want=0000001", outs_a);
        end
        @(negedge clk);
        set_in(3, 0, 1, 0, 1, 3, 1, 1, 1);
        #1;
        checks++;
        if (outs_a !== 7'b1111_110) begin
            failures++;
            $display("FAIL wait_ready_redirect got=%b want=1111110", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        set_in(3, 0, 1, 0, 1, 3, 0, 1, 1);
        #1;
        checks++;
        if (outs_a !== 7'b0011_010) begin
            failures++;
            $display("FAIL wait_ready_hazard got=%b want=0011010", outs_a);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_a !== 32'd6) begin
            failures++;
            $display("FAIL mem_wait_total got=%0d want=6", stall_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (timeout_b !== (k >= 5) || timeout_a !== 1'b0 || pc_en_b !== 1'b0) begin
                failures++;
                $display("FAIL timeout_edge_%0d to_b=%b to_a=%b pc_en=%b want to_b=%b to_a=0 pc_en=0",
                         k, timeout_b, timeout_a, pc_en_b, (k >= 5));
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (outs_b !== 7'b1111_000 || stall_b !== 4'd6) begin
            failures++;
            $display("FAIL timeout_release outs=%b stall=%0d want=1111000 stall=6", outs_b, stall_b);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (timeout_b !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b want=1", timeout_b);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (timeout_b !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b want=0", timeout_b);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) @(negedge clk);
        checks++;
        if (stall_b !== 4'd15 || stall_a !== 32'd20) begin
            failures++;
            $display("FAIL stall_saturate b=%0d a=%0d want b=15 a=20", stall_b, stall_a);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (outs_a !== 7'b0000_111 || stall_a !== 32'd0 || stall_b !== 4'd0 || timeout_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait outs=%b sa=%0d sb=%0d to_b=%b want 0000111 0 0 0",
                     outs_a, stall_a, stall_b, timeout_b);
        end
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs_a !== 7'b1111_000) begin
            failures++;
            $display("FAIL reset_abort_run got=%b want=1111000", outs_a);
        end
        @(negedge clk);
        checks++;
        if (stall_a !== 32'd0 || stall_b !== 4'd0) begin
            failures++;
            $display("FAIL reset_no_retain a=%0d b=%0d want 0", stall_a, stall_b);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_o;
        do_reset();
        m_wait = 1'b0; m_wc = 0; m_stall_a = 0; m_stall_b = 0; m_to_a = 1'b0; m_to_b = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if (stall_a !== 32'(m_stall_a) || stall_b !== 4'(m_stall_b) ||
                timeout_a !== m_to_a || timeout_b !== m_to_b) begin
                failures++;
                $display("FAIL rand_regs n=%0d sa=%0d sb=%0d ta=%b tb=%b want %0d %0d %b %b",
                         n, stall_a, stall_b, timeout_a, timeout_b, m_stall_a, m_stall_b, m_to_a, m_to_b);
            end
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), (m_wait || $urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) < ((n / 500) % 2 == 1 ? 2 : 6)));
            #1;
            exp_o = model_outs();
            checks++;
            if (outs_a !== exp_o || outs_b !== exp_o) begin
                failures++;
                $display("FAIL rand_outs n=%0d a=%b b=%b want=%b", n, outs_a, outs_b, exp_o);
            end
            @(posedge clk);
            model_update();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_x0_redirect();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
